// File: rtl/sram_pkg.sv
// Shared types and helpers for the simple-dual-port SRAM family.
// Holds the clear-engine state encoding and the byte-lane merge used by writes and bypass.
package sram_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_INIT  = 1'b0;
  localparam state_t ST_READY = 1'b1;

  // Widest word the merge helper handles; narrower words are zero-padded by the caller.
  localparam int MAX_DW = 256;
  localparam int MAX_BE = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_word,
    input logic [MAX_DW-1:0] new_word,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Clear-engine controller: walks every word once after reset or on request,
// then holds the array in the ready state.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_req,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] cnt;

  // A request arriving mid-clear is dropped so the sweep never restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      if (cnt == LAST) begin
        state <= ST_READY;
        cnt   <= '0;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end else if (init_req) begin
      state <= ST_INIT;
      cnt   <= '0;
    end
  end

  assign init_we   = (state == ST_INIT);
  assign init_addr = cnt;
  assign init_done = (state == ST_READY);

endmodule

// File: rtl/sram_dp_init.sv
// Simple-dual-port SRAM with byte enables, write-first bypass and a hardware clear engine.
// Define SRAM_OUT_REG_EN to add a second output register (read latency 2).
module sram_dp_init
  import sram_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            AW       = 4,
  parameter int            DEPTH    = 16,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init_req,
  input  logic            wren,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wbe,
  input  logic            rden,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata,
  output logic            rvalid,
  output logic            init_done
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic          init_we;
  logic [AW-1:0] init_addr;
  logic          ready;
  logic          wr_ok;
  logic          rd_ok;
  logic [DW-1:0] wold;
  logic [DW-1:0] wmerged;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] rdata1;
  logic          rvalid1;

  sram_init_ctrl #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_init_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done)
  );

  assign ready = init_done;
  assign wr_ok = ready && wren && ({1'b0, waddr} < DEPTH_W);
  assign rd_ok = ({1'b0, raddr} < DEPTH_W);

  always_comb begin
    wold = '0;
    if (wr_ok) wold = mem[waddr[IW-1:0]];
  end

  assign wmerged = DW'(lane_merge(MAX_DW'(wold), MAX_DW'(wdata), MAX_BE'(wbe)));

  // Same-address read sees the word as it will look after this cycle's write.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      if (wr_ok && (waddr == raddr)) rd_word = wmerged;
      else                           rd_word = mem[raddr[IW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (init_we)    mem[init_addr[IW-1:0]] <= INIT_VAL;
    else if (wr_ok) mem[waddr[IW-1:0]]     <= wmerged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1  <= '0;
      rvalid1 <= 1'b0;
    end else if (ready && rden) begin
      rdata1  <= rd_word;
      rvalid1 <= 1'b1;
    end else begin
      rvalid1 <= 1'b0;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DW-1:0] rdata2;
  logic          rvalid2;

  // While clearing, anything still travelling through the pipe is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata2  <= '0;
      rvalid2 <= 1'b0;
    end else if (!ready) begin
      rvalid2 <= 1'b0;
    end else begin
      rvalid2 <= rvalid1;
      if (rvalid1) rdata2 <= rdata1;
    end
  end

  assign rdata  = rdata2;
  assign rvalid = rvalid2;
`else
  assign rdata  = rdata1;
  assign rvalid = rvalid1;
`endif

endmodule

// File: tb/tb_sram_dp_init.sv
// Bench for sram_dp_init (DW=16, AW=5, DEPTH=16): directed scenarios then random traffic,
// all outputs compared each cycle against a word-array reference model.
module tb_sram_dp_init;

  localparam int            DW       = 16;
  localparam int            AW       = 5;
  localparam int            DEPTH    = 16;
  localparam int            NB       = DW / 8;
  localparam int            IW       = 4;
  localparam logic [DW-1:0] INIT_VAL = 16'h5AC3;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          init_req = 1'b0;
  logic          wren     = 1'b0;
  logic [AW-1:0] waddr    = '0;
  logic [DW-1:0] wdata    = '0;
  logic [NB-1:0] wbe      = '0;
  logic          rden     = 1'b0;
  logic [AW-1:0] raddr    = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          init_done;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mmem [DEPTH];
  bit            m_ready;
  int            m_clear_idx;
  logic [DW-1:0] m_rdata;
  bit            m_rvalid;
  bit            p_valid;
  logic [DW-1:0] p_data;

  sram_dp_init #(
    .DW       (DW),
    .AW       (AW),
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .wren      (wren),
    .waddr     (waddr),
    .wdata     (wdata),
    .wbe       (wbe),
    .rden      (rden),
    .raddr     (raddr),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ready     = 1'b0;
    m_clear_idx = 0;
    m_rdata     = '0;
    m_rvalid    = 1'b0;
    p_valid     = 1'b0;
    p_data      = '0;
  endtask

  // Applies one clock edge of the rules to the model using the inputs currently driven.
  task automatic model_edge();
    bit            was_ready;
    bit            rv;
    logic [DW-1:0] rd;
    was_ready = m_ready;
    rv = 1'b0;
    rd = '0;
    if (was_ready) begin
      if (wren && int'(waddr) < DEPTH) begin
        for (int i = 0; i < NB; i++)
          if (wbe[i]) mmem[waddr[IW-1:0]][8*i +: 8] = wdata[8*i +: 8];
      end
      if (rden) begin
        rv = 1'b1;
        rd = (int'(raddr) < DEPTH) ? mmem[raddr[IW-1:0]] : '0;
      end
      if (init_req) begin
        m_ready     = 1'b0;
        m_clear_idx = 0;
      end
    end else begin
      mmem[m_clear_idx] = INIT_VAL;
      m_clear_idx++;
      if (m_clear_idx == DEPTH) m_ready = 1'b1;
    end
    if (LAT == 1) begin
      m_rvalid = rv;
      if (rv) m_rdata = rd;
    end else if (!was_ready) begin
      m_rvalid = 1'b0;
      p_valid  = 1'b0;
    end else begin
      m_rvalid = p_valid;
      if (p_valid) m_rdata = p_data;
      p_valid = rv;
      p_data  = rd;
    end
  endtask

  task automatic check_val(input string tag, input logic [DW-1:0] observed,
                           input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ".rdata"}, rdata, m_rdata);
    check_val({tag, ".rvalid"}, DW'(rvalid), DW'(m_rvalid));
    check_val({tag, ".init_done"}, DW'(init_done), DW'(m_ready));
  endtask

  task automatic apply_stimulus(input bit ir, input bit we, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic [NB-1:0] be,
                                input bit re, input logic [AW-1:0] ra, input string tag);
    init_req = ir;
    wren     = we;
    waddr    = wa;
    wdata    = wd;
    wbe      = be;
    rden     = re;
    raddr    = ra;
    @(posedge clk);
    #1;
    model_edge();
    check_output(tag);
    init_req = 1'b0;
    wren     = 1'b0;
    rden     = 1'b0;
  endtask

  task automatic idle(input string tag);
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, tag);
  endtask

  task automatic write_word(input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [NB-1:0] be);
    apply_stimulus(1'b0, 1'b1, wa, wd, be, 1'b0, '0, "write");
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] ra,
                            input logic [DW-1:0] expected);
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, ra, tag);
    for (int k = 1; k < LAT; k++) idle(tag);
    check_val({tag, ".value"}, rdata, expected);
    check_val({tag, ".valid"}, DW'(rvalid), DW'(1'b1));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val({tag, ".rdata"}, rdata, '0);
    check_val({tag, ".rvalid"}, DW'(rvalid), '0);
    check_val({tag, ".init_done"}, DW'(init_done), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts edges until init_done rises; optionally pokes writes/reads and one init_req mid-clear.
  task automatic wait_init(input string tag, input bit busy, input int req_at);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      apply_stimulus(n == req_at, busy, 5'd3, 16'hFFFF, 2'b11, busy, 5'd3, tag);
      n++;
    end
    check_val({tag, ".clear_cycles"}, DW'(n), DW'(DEPTH));
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      idle("settle");
      n++;
    end
    check_val("settle.ready", DW'(init_done), DW'(1'b1));
  endtask

  logic [AW-1:0] r_wa;
  logic [AW-1:0] r_ra;
  logic [DW-1:0] r_wd;
  logic [NB-1:0] r_be;
  bit            r_we;
  bit            r_re;
  bit            r_ir;

  initial begin
    model_reset();
    #1;
    do_reset("reset");
    wait_init("init_after_reset", 1'b1, 4);
    read_check("ignored_write_addr3", 5'd3, INIT_VAL);

    for (int a = 0; a < DEPTH; a++)
      apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(a), $sformatf("read_all_%0d", a));
    for (int k = 0; k < LAT; k++) idle("read_all_drain");

    write_word(5'd1, 16'hAAAA, 2'b11);
    write_word(5'd1, 16'h5555, 2'b01);
    read_check("byte_lanes", 5'd1, 16'hAA55);

    write_word(5'd2, 16'h1234, 2'b11);
    apply_stimulus(1'b0, 1'b1, 5'd2, 16'hABCD, 2'b10, 1'b1, 5'd2, "collision");
    for (int k = 1; k < LAT; k++) idle("collision");
    check_val("collision.value", rdata, 16'hAB34);

    write_word(5'd2, 16'hFFFF, 2'b00);
    read_check("wbe_zero", 5'd2, 16'hAB34);

    write_word(5'd18, 16'hEEEE, 2'b11);
    read_check("out_of_range_read", 5'd18, 16'h0000);
    read_check("out_of_range_no_alias", 5'd2, 16'hAB34);

    write_word(5'd5, 16'h000F, 2'b11);
    apply_stimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, 5'd5, "init_req_with_read");
    wait_init("init_req_clear", 1'b0, 5);
    read_check("addr5_cleared", 5'd5, INIT_VAL);

    for (int k = 0; k < 400; k++) begin
      r_wa = AW'($urandom_range(0, 19));
      r_ra = ($urandom_range(0, 3) == 0) ? r_wa : AW'($urandom_range(0, 19));
      r_wd = DW'($urandom);
      r_be = NB'($urandom);
      r_we = ($urandom_range(0, 3) != 0);
      r_re = ($urandom_range(0, 3) != 0);
      r_ir = ($urandom_range(0, 39) == 0);
      apply_stimulus(r_ir, r_we, r_wa, r_wd, r_be, r_re, r_ra, $sformatf("random_%0d", k));
    end

    settle();
    for (int k = 0; k < LAT; k++)
      apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(4 + k), "read_before_reset");
    check_val("rvalid_before_reset", DW'(rvalid), DW'(1'b1));
    do_reset("reset_mid_read");
    wait_init("init_after_reset_mid_read", 1'b0, -1);
    read_check("post_reset_read", 5'd4, INIT_VAL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_dp_init.md
Name: sram_dp_init

Overview:
Parametrised simple-dual-port SRAM (1 write port, 1 read port) on one clock. Successor to the 4x8 single-port sram; used as generic buffer storage across the IP library.
- Adds per-byte write enables.
- Adds a registered read with a valid strobe.
- Adds write-first bypass on same-address collisions.
- Adds a hardware clear engine that fills the array with INIT_VAL after reset or on request.

Parameters:
DW, 8, data width in bits; must be a multiple of 8
AW, 4, address width
DEPTH, 16, number of words; must be ≤ 2**AW
INIT_VAL, 0, DW-bit value written to every word by the clear engine

Ports:
CLK  in  1  clock, rising-edge
RST_N  in  1  reset, asynchronous assert, active-low
INIT_REQ  in  1  single-cycle pulse; restarts the clear sequence
WREN  in  1  write request
WADDR  in  AW  write address
WDATA  in  DW  write data
WBE  in  DW/8  byte-lane write enables; bit i covers WDATA[8i+7:8i]
RDEN  in  1  read request
RADDR  in  AW  read address
RDATA  out  DW  registered read data
RVALID  out  1  RDATA valid strobe
INIT_DONE  out  1  high when the array is usable

Behaviour:
- Reset (RST_N=0, asynchronous): RDATA=0, RVALID=0, INIT_DONE=0, FSM=ST_INIT, clear counter=0. Array contents are not reset directly; the clear engine clears them.
- ST_INIT:
  - Each cycle writes INIT_VAL to word[cnt], then cnt++.
  - After writing word DEPTH-1, go to ST_READY; INIT_DONE=1 from the following cycle.
  - The clear takes exactly DEPTH cycles after reset release.
  - WREN and RDEN are ignored: no array write, RVALID=0, RDATA holds.
- ST_READY:
  - INIT_REQ=1 → ST_INIT, cnt=0, INIT_DONE=0 at the next edge.
  - A user write or read in the same cycle as INIT_REQ is still performed.
  - INIT_REQ while already in ST_INIT is ignored; the counter does not restart.
- Write:
  - WREN=1 in ST_READY with WADDR<DEPTH: for each i with WBE[i]=1, lane i of word[WADDR] takes the WDATA lane.
  - Other lanes are unchanged.
  - WBE=0 means no change.
- Read:
  - RDEN=1 in ST_READY: at the next edge RDATA=word[RADDR] and RVALID=1 for one cycle (latency 1).
  - RDEN=0: RVALID=0 and RDATA holds its last value.
  - Back-to-back reads give one result per cycle.
- Collision:
  - WREN and RDEN both asserted with WADDR==RADDR gives write-first behaviour.
  - RDATA returns the merged word: enabled lanes from WDATA, other lanes from the old contents.
  - Different addresses do not interact.
- Out of range (address ≥ DEPTH, only possible when DEPTH<2**AW):
  - The write is dropped.
  - The read returns 0 with RVALID=1.
- Reset mid-clear or mid-read: everything restarts from the reset state and the clear runs again from word 0. An in-flight RVALID is lost.

Optional Feature:
SRAM_OUT_REG_EN
- Defined: adds a second output register. Read latency becomes 2 and RVALID is delayed to match.
  - The collision merge is still computed in stage 1.
  - Both stages reset to 0.
  - Both stages flush to RVALID=0 when the block enters ST_INIT.
- Undefined: latency 1 as described above.

Decomposition:
- Package sram_pkg: state enum (ST_INIT, ST_READY) and a lane-merge function.
- Natural sub-module: sram_init_ctrl, containing the FSM and the clear counter. Outputs: init write enable, init address, INIT_DONE.

Test Plan:
- Release reset, DEPTH=16 → INIT_DONE rises exactly 16 cycles later; read every address → all 0x00, RVALID 1 cycle after each RDEN.
- Reads and writes during ST_INIT: WREN=1 WADDR=3 WDATA=0xFF → ignored; after init, read addr 3 → 0x00; RVALID stays 0 throughout the clear.
- Byte lanes, DW=16: write 0xAAAA WBE=11 to addr 1, then 0x5555 WBE=01 → read addr 1 = 0xAA55.
- Collision, DW=16: addr 2 holds 0x1234; in the same cycle write 0xABCD WBE=10 and read addr 2 → RDATA=0xAB34 next cycle.
- INIT_REQ after writing 0x0F to addr 5 → INIT_DONE drops for 16 cycles, then read addr 5 = 0x00; INIT_REQ pulsed mid-clear does not extend the clear.
- With SRAM_OUT_REG_EN defined: RDEN on cycles n and n+1 → RVALID high on n+2 and n+3, correct data; assert RST_N=0 at n+1 → RVALID=0 immediately.
